vid_pattern_gen: RTL and testbench

// Synthesisable, parametrised video source: raster timing generator (sync, valid) plus multi-channel test-pattern data.

---
 rtl/vid_pkg.sv | 38 +++
 rtl/vid_timing_cnt.sv | 113 +++++++++++
 rtl/vid_pattern_gen.sv | 199 +++++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_pkg
// Description : Shared types and helpers for the video pattern source and any
//               sinks or checkers that need the same raster description.
//                 - vid_mode_t   : pattern selector encoding
//                 - vid_timing_t : one axis of raster timing (sync/back/disp/front)
//                 - vid_total    : total length of one axis
// Revision    : 1.0  initial release
// ============================================================================
package vid_pkg;

    // Counter and coordinate width used across the raster logic
    localparam int c_CW = 16;

    // Colour-bar count across the active width
    localparam int c_NUM_BARS = 8;

    typedef enum logic [1:0] {
        VID_HRAMP = 2'd0,
        VID_VRAMP = 2'd1,
        VID_BARS  = 2'd2,
        VID_CHECK = 2'd3
    } vid_mode_t;

    typedef struct packed {
        logic [c_CW-1:0] sync;
        logic [c_CW-1:0] back;
        logic [c_CW-1:0] disp;
        logic [c_CW-1:0] front;
    } vid_timing_t;

    function automatic int vid_total(input vid_timing_t t);
        return int'(t.sync) + int'(t.back) + int'(t.disp) + int'(t.front);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_timing_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_cnt
// Description : Horizontal/vertical raster counters with frame wrap, sync and
//               active-area decode, active x/y and colour-bar index.
// Ports       : clk, rst       clock, synchronous active-high reset
//               i_run          advance the counters by one pixel this cycle
//               o_first        counters sit on pixel (0,0)
//               o_last         counters sit on the frame's final pixel
//               o_hsync_act    horizontal sync region
//               o_vsync_act    vertical sync region
//               o_active       inside the displayed area
//               o_x, o_y       active column/row (valid only when o_active)
//               o_bar          colour-bar index 0..7 for the current column
// Revision    : 1.0  initial release
// ============================================================================
module vid_timing_cnt
    import vid_pkg::*;
#(
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_run,
    output logic            o_first,
    output logic            o_last,
    output logic            o_hsync_act,
    output logic            o_vsync_act,
    output logic            o_active,
    output logic [c_CW-1:0] o_x,
    output logic [c_CW-1:0] o_y,
    output logic [2:0]      o_bar
);

    localparam vid_timing_t c_HT = '{sync: 16'(H_SYNC), back: 16'(H_BACK),
                                     disp: 16'(H_DISP), front: 16'(H_FRONT)};
    localparam vid_timing_t c_VT = '{sync: 16'(V_SYNC), back: 16'(V_BACK),
                                     disp: 16'(V_DISP), front: 16'(V_FRONT)};

    localparam int c_H_TOTAL = vid_total(c_HT);
    localparam int c_V_TOTAL = vid_total(c_VT);

    localparam logic [c_CW-1:0] c_ONE      = 16'd1;
    localparam logic [c_CW-1:0] c_H_LAST   = 16'(c_H_TOTAL - 1);
    localparam logic [c_CW-1:0] c_V_LAST   = 16'(c_V_TOTAL - 1);
    localparam logic [c_CW-1:0] c_H_SYNC   = 16'(H_SYNC);
    localparam logic [c_CW-1:0] c_V_SYNC   = 16'(V_SYNC);
    localparam logic [c_CW-1:0] c_H_ACT0   = 16'(H_SYNC + H_BACK);
    localparam logic [c_CW-1:0] c_H_ACT1   = 16'(H_SYNC + H_BACK + H_DISP);
    localparam logic [c_CW-1:0] c_V_ACT0   = 16'(V_SYNC + V_BACK);
    localparam logic [c_CW-1:0] c_V_ACT1   = 16'(V_SYNC + V_BACK + V_DISP);
    localparam logic [c_CW-1:0] c_BAR_LAST = 16'(H_DISP / c_NUM_BARS - 1);

    logic [c_CW-1:0] r_h_cnt;
    logic [c_CW-1:0] r_v_cnt;
    logic [c_CW-1:0] r_bar_pix;
    logic [2:0]      r_bar;
    logic [c_CW-1:0] w_h_next;
    logic            w_h_wrap;
    logic            w_h_act;
    logic            w_v_act;

    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h_cnt + c_ONE;
    assign w_h_act  = (r_h_cnt >= c_H_ACT0) && (r_h_cnt < c_H_ACT1);
    assign w_v_act  = (r_v_cnt >= c_V_ACT0) && (r_v_cnt < c_V_ACT1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_pix <= '0;
            r_bar     <= '0;
        end else if (i_run) begin
            r_h_cnt <= w_h_next;
            if (w_h_wrap) begin
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_ONE;
            end
            // Bar position is tracked incrementally so no divider is needed.
            // It restarts as the next column becomes the first active one; the
            // final bar saturates so it absorbs any remainder of H_DISP/8.
            if (w_h_next == c_H_ACT0) begin
                r_bar_pix <= '0;
                r_bar     <= '0;
            end else if (w_h_act) begin
                if ((r_bar_pix == c_BAR_LAST) && (r_bar != 3'd7)) begin
                    r_bar_pix <= '0;
                    r_bar     <= r_bar + 3'd1;
                end else begin
                    r_bar_pix <= r_bar_pix + c_ONE;
                end
            end
        end
    end

    assign o_first     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_last      = w_h_wrap && (r_v_cnt == c_V_LAST);
    assign o_hsync_act = (r_h_cnt < c_H_SYNC);
    assign o_vsync_act = (r_v_cnt < c_V_SYNC);
    assign o_active    = w_h_act && w_v_act;
    assign o_x         = r_h_cnt - c_H_ACT0;
    assign o_y         = r_v_cnt - c_V_ACT0;
    assign o_bar       = r_bar;

endmodule
`default_nettype wire

// File: rtl/vid_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vid_pattern_gen
// Description : Parametrised video source: raster timing (sync, valid) plus
//               multi-channel test-pattern pixel data with start/stop control.
// Ports       : clk             pixel clock
//               rst             synchronous active-high reset
//               en              run request, honoured on frame boundaries only
//               mode            0 h-ramp, 1 v-ramp, 2 colour bars, 3 checker
//               post_img_vsync  vertical sync (SYNC_POL)
//               post_img_hsync  horizontal sync (SYNC_POL)
//               post_img_valid  active-pixel qualifier
//               post_img_data   pixel, channel c at [c*DATA_W +: DATA_W]
//               frame_start     one-cycle pulse on each frame's first output
//               frame_cnt       completed frames, wraps
//               busy            high while a frame is being output
// Revision    : 1.0  initial release
// ============================================================================
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int H_DISP   = 1280,
    parameter int H_FRONT  = 110,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int V_DISP   = 720,
    parameter int V_FRONT  = 5,
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int CHK_LOG2 = 4,
    parameter int SYNC_POL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    output logic                         post_img_vsync,
    output logic                         post_img_hsync,
    output logic                         post_img_valid,
    output logic [CHANNELS*DATA_W-1:0]   post_img_data,
    output logic                         frame_start,
    output logic [15:0]                  frame_cnt,
    output logic                         busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic c_SYNC_ON = (SYNC_POL != 0);

    generate
        if (H_SYNC < 1 || H_BACK < 1 || H_DISP < 8 || H_FRONT < 1 ||
            V_SYNC < 1 || V_BACK < 1 || V_DISP < 1 || V_FRONT < 1) begin : g_bad_timing
            $error("vid_pattern_gen: timing fields must be >= 1 and H_DISP >= 8");
        end
        if ((H_SYNC + H_BACK + H_DISP + H_FRONT) > 65536 ||
            (V_SYNC + V_BACK + V_DISP + V_FRONT) > 65536) begin : g_bad_total
            $error("vid_pattern_gen: raster totals must fit 16-bit counters");
        end
        if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
            $error("vid_pattern_gen: CHANNELS must be 1..4");
        end
        if (DATA_W < 1) begin : g_bad_data_w
            $error("vid_pattern_gen: DATA_W must be >= 1");
        end
    endgenerate

    logic [0:0]                 r_state;
    vid_mode_t                  r_mode;
    logic                       r_last_d;
    logic                       r_vsync;
    logic                       r_hsync;
    logic                       r_valid;
    logic [CHANNELS*DATA_W-1:0] r_data;
    logic                       r_frame_start;
    logic [15:0]                r_frame_cnt;
    logic                       r_busy;

    logic                       w_run;
    logic                       w_first;
    logic                       w_last;
    logic                       w_hsync_act;
    logic                       w_vsync_act;
    logic                       w_active;
    logic [c_CW-1:0]            w_x;
    logic [c_CW-1:0]            w_y;
    logic [2:0]                 w_bar;
    logic [DATA_W-1:0]          w_x_ramp;
    logic [DATA_W-1:0]          w_y_ramp;
    logic [c_CW-1:0]            w_x_cell;
    logic [c_CW-1:0]            w_y_cell;
    logic                       w_chk;
    logic [CHANNELS*DATA_W-1:0] w_pix;

    assign w_run = (r_state == S_RUN);

    vid_timing_cnt #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_DISP  (H_DISP),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_DISP  (V_DISP),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .o_first     (w_first),
        .o_last      (w_last),
        .o_hsync_act (w_hsync_act),
        .o_vsync_act (w_vsync_act),
        .o_active    (w_active),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_bar       (w_bar)
    );

    // Ramps wrap naturally by truncating the coordinate to the channel width
    assign w_x_ramp = DATA_W'(w_x);
    assign w_y_ramp = DATA_W'(w_y);
    assign w_x_cell = w_x >> CHK_LOG2;
    assign w_y_cell = w_y >> CHK_LOG2;
    assign w_chk    = w_x_cell[0] ^ w_y_cell[0];

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            // Channel c lights on bar-index bit (c % 3): R/G/B-style bar order
            localparam int c_BIT = c % 3;
            assign w_pix[c*DATA_W +: DATA_W] =
                (r_mode == VID_HRAMP) ? w_x_ramp :
                (r_mode == VID_VRAMP) ? w_y_ramp :
                (r_mode == VID_BARS)  ? {DATA_W{w_bar[c_BIT]}} :
                                        {DATA_W{w_chk}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mode        <= VID_HRAMP;
            r_last_d      <= 1'b0;
            r_vsync       <= ~c_SYNC_ON;
            r_hsync       <= ~c_SYNC_ON;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
            r_busy        <= 1'b0;
        end else begin
            // Start/stop decisions and mode sampling happen only on frame
            // boundaries so a frame is never torn.
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_RUN;
                        r_mode  <= vid_mode_t'(mode);
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        if (en) begin
                            r_mode <= vid_mode_t'(mode);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_vsync       <= (w_run && w_vsync_act) ? c_SYNC_ON : ~c_SYNC_ON;
            r_hsync       <= (w_run && w_hsync_act) ? c_SYNC_ON : ~c_SYNC_ON;
            r_valid       <= w_run && w_active;
            r_data        <= (w_run && w_active) ? w_pix : '0;
            r_frame_start <= w_run && w_first;
            r_busy        <= w_run;

            // The count steps the cycle after the last pixel leaves the port
            r_last_d <= w_run && w_last;
            if (r_last_d) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign post_img_vsync = r_vsync;
    assign post_img_hsync = r_hsync;
    assign post_img_valid = r_valid;
    assign post_img_data  = r_data;
    assign frame_start    = r_frame_start;
    assign frame_cnt      = r_frame_cnt;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vid_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_pattern_gen
// Description : Self-checking bench for vid_pattern_gen on a small raster
//               (H 4/4/16/4, V 2/2/8/2, 8-bit, 3 channels, 4-pixel checker).
//               A pixel-index reference model predicts every output cycle;
//               directed frames pin specific values, then random en/mode/rst.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vid_pattern_gen;

    localparam int c_H_SYNC = 4;
    localparam int c_H_BACK = 4;
    localparam int c_H_DISP = 16;
    localparam int c_H_TOT  = 28;
    localparam int c_V_SYNC = 2;
    localparam int c_V_BACK = 2;
    localparam int c_V_DISP = 8;
    localparam int c_V_TOT  = 14;
    localparam int c_FRAME  = c_H_TOT * c_V_TOT;
    localparam int c_CHK    = 2;

    logic        clk;
    logic        rst;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        w_vsync;
    logic        w_hsync;
    logic        w_valid;
    logic [23:0] w_data;
    logic        w_fs;
    logic [15:0] w_fcnt;
    logic        w_busy;

    int n_pass  = 0;
    int n_total = 0;

    vid_pattern_gen #(
        .H_SYNC (c_H_SYNC), .H_BACK (c_H_BACK), .H_DISP (c_H_DISP), .H_FRONT (4),
        .V_SYNC (c_V_SYNC), .V_BACK (c_V_BACK), .V_DISP (c_V_DISP), .V_FRONT (2),
        .DATA_W (8), .CHANNELS (3), .CHK_LOG2 (c_CHK), .SYNC_POL (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (r_en),
        .mode           (r_mode),
        .post_img_vsync (w_vsync),
        .post_img_hsync (w_hsync),
        .post_img_valid (w_valid),
        .post_img_data  (w_data),
        .frame_start    (w_fs),
        .frame_cnt      (w_fcnt),
        .busy           (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Pattern value for active coordinate (x,y) straight from the mode rules
    function automatic logic [23:0] pattern(input int md, input int x, input int y);
        logic [7:0] ch [3];
        int b;
        for (int c = 0; c < 3; c++) begin
            case (md)
                0: ch[c] = 8'(x % 256);
                1: ch[c] = 8'(y % 256);
                2: begin
                    b = x / (c_H_DISP / 8);
                    if (b > 7) b = 7;
                    ch[c] = (((b >> (c % 3)) & 1) != 0) ? 8'hFF : 8'h00;
                end
                default: ch[c] = ((((x >> c_CHK) ^ (y >> c_CHK)) & 1) != 0) ? 8'hFF : 8'h00;
            endcase
        end
        return {ch[2], ch[1], ch[0]};
    endfunction

    // ---------------- reference model: frame as a linear pixel index -------
    bit          m_started = 1'b0;
    bit          m_run;
    bit          m_pend;
    int          m_pos;
    int          m_mode;
    int          m_fcnt;
    int          m_h;
    int          m_v;
    logic        m_vs;
    logic        m_hs;
    logic        m_act;
    logic        m_fs;
    logic        m_bz;
    logic [23:0] m_d;
    logic [44:0] m_exp;

    always @(posedge clk) begin
        if (rst) begin
            m_run  = 1'b0;
            m_pend = 1'b0;
            m_pos  = 0;
            m_fcnt = 0;
            m_exp  = '0;
        end else begin
            if (m_pend) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                m_pend = 1'b0;
            end
            m_vs = 1'b0; m_hs = 1'b0; m_act = 1'b0; m_fs = 1'b0; m_bz = 1'b0; m_d = '0;
            if (m_run) begin
                m_h   = m_pos % c_H_TOT;
                m_v   = m_pos / c_H_TOT;
                m_vs  = (m_v < c_V_SYNC);
                m_hs  = (m_h < c_H_SYNC);
                m_act = (m_h >= c_H_SYNC + c_H_BACK) && (m_h < c_H_SYNC + c_H_BACK + c_H_DISP) &&
                        (m_v >= c_V_SYNC + c_V_BACK) && (m_v < c_V_SYNC + c_V_BACK + c_V_DISP);
                m_fs  = (m_pos == 0);
                m_bz  = 1'b1;
                if (m_act) m_d = pattern(m_mode, m_h - c_H_SYNC - c_H_BACK, m_v - c_V_SYNC - c_V_BACK);
                m_pos++;
                if (m_pos == c_FRAME) begin
                    m_pos  = 0;
                    m_pend = 1'b1;
                    m_run  = r_en;
                    if (r_en) m_mode = int'(r_mode);
                end
            end else if (r_en) begin
                m_run  = 1'b1;
                m_pos  = 0;
                m_mode = int'(r_mode);
            end
            m_exp = {m_vs, m_hs, m_act, m_d, m_fs, 16'(m_fcnt), m_bz};
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started)
            check("cycle_outputs", {w_vsync, w_hsync, w_valid, w_data, w_fs, w_fcnt, w_busy}, m_exp);
    end

    // ---------------- directed frames --------------------------------------
    // Entered on the negedge showing pixel 0; leaves on the one showing the last pixel.
    task automatic play_frame(input int fno, output int n_vs, output int n_hs, output int n_va);
        n_vs = 0; n_hs = 0; n_va = 0;
        for (int k = 0; k < c_FRAME; k++) begin
            if (k > 0) @(negedge clk);
            n_vs += int'(w_vsync);
            n_hs += int'(w_hsync);
            n_va += int'(w_valid);
            case (fno)
                1: begin
                    if (k == 168) r_mode = 2'd1;
                    if (k == 120) check("f1_hramp_x0", w_data, 24'h000000);
                    if (k == 209) check("f1_hramp_after_mode_chg", w_data, 24'h050505);
                    if (k == 331) check("f1_hramp_x15", w_data, 24'h0F0F0F);
                end
                2: begin
                    if (k == 200) r_mode = 2'd2;
                    if (k == 115) check("f2_blank_data", w_data, 24'h000000);
                    if (k == 300) check("f2_vramp_y6", w_data, 24'h060606);
                    if (k == 316) check("f2_vramp_y7", w_data, 24'h070707);
                end
                3: begin
                    if (k == 250) r_mode = 2'd3;
                    if (k == 150) check("f3_bar1", w_data, 24'h0000FF);
                    if (k == 151) check("f3_bar1b", w_data, 24'h0000FF);
                    if (k == 154) check("f3_bar3", w_data, 24'h00FFFF);
                    if (k == 156) check("f3_bar4", w_data, 24'hFF0000);
                    if (k == 163) check("f3_bar7", w_data, 24'hFFFFFF);
                end
                4: begin
                    if (k == 84)  r_en = 1'b0;
                    if (k == 120) check("f4_chk_x0y0", w_data, 24'h000000);
                    if (k == 124) check("f4_chk_x4y0", w_data, 24'hFFFFFF);
                    if (k == 232) check("f4_chk_x0y4", w_data, 24'hFFFFFF);
                    if (k == 236) check("f4_chk_x4y4", w_data, 24'h000000);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        int n_vs, n_hs, n_va;

        rst = 1'b1; r_en = 1'b0; r_mode = 2'd0;

        // Model pins
        check("model_bar4", pattern(2, 8, 0), 24'hFF0000);
        check("model_chk", pattern(3, 4, 0), 24'hFFFFFF);
        check("model_vramp", pattern(1, 3, 5), 24'h050505);

        repeat (3) @(negedge clk);
        check("rst_vsync", w_vsync, 1'b0);
        check("rst_busy", w_busy, 1'b0);
        check("rst_fcnt", w_fcnt, 16'd0);
        check("rst_data", w_data, 24'h0);
        rst = 1'b0;
        @(negedge clk);
        r_en = 1'b1; r_mode = 2'd0;
        @(negedge clk);
        check("fs_not_yet", w_fs, 1'b0);
        check("busy_not_yet", w_busy, 1'b0);
        @(negedge clk);
        check("fs_first", w_fs, 1'b1);
        check("busy_first", w_busy, 1'b1);

        play_frame(1, n_vs, n_hs, n_va);
        check("f1_vsync_cycles", n_vs, 56);
        check("f1_hsync_cycles", n_hs, 56);
        check("f1_valid_cycles", n_va, 128);
        @(negedge clk);
        check("f2_fs", w_fs, 1'b1);
        check("f2_fcnt", w_fcnt, 16'd1);
        play_frame(2, n_vs, n_hs, n_va);
        @(negedge clk);
        check("f3_fcnt", w_fcnt, 16'd2);
        play_frame(3, n_vs, n_hs, n_va);
        @(negedge clk);
        check("f4_fcnt", w_fcnt, 16'd3);
        play_frame(4, n_vs, n_hs, n_va);
        check("f4_valid_cycles", n_va, 128);
        @(negedge clk);
        check("stop_busy", w_busy, 1'b0);
        check("stop_fcnt", w_fcnt, 16'd4);
        check("stop_fs", w_fs, 1'b0);
        repeat (5) @(negedge clk);
        check("idle_busy", w_busy, 1'b0);
        check("idle_vsync", w_vsync, 1'b0);

        // Restart, then reset in the middle of the frame
        r_en = 1'b1;
        @(negedge clk);
        check("restart_fs_not_yet", w_fs, 1'b0);
        @(negedge clk);
        check("restart_fs", w_fs, 1'b1);
        repeat (178) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fcnt", w_fcnt, 16'd0);
        check("midrst_busy", w_busy, 1'b0);
        check("midrst_valid", w_valid, 1'b0);
        rst = 1'b0;

        // Random run/stop, mode changes and rare resets against the model
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            r_en = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 49) == 0) r_mode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 4999) == 0);
        end
        @(negedge clk);
        rst = 1'b0; r_en = 1'b0;
        repeat (c_FRAME + 10) @(negedge clk);
        check("end_idle_busy", w_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
